mem_burst_initiator: RTL and testbench

- Initiator for the single-port word memory interface (address, write data, write enable, read data) used across our parameterised memory test blocks.
- Accepts one burst command at a time (write or read, base address, length).
- Write bursts: streams data from a valid/ready source into sequential memory addresses.
- Read bursts: fetches sequential words and presents them on a valid/ready sink.
- Sits between a host/test sequencer and the memory responder.

---
 rtl/mem_burst_initiator.sv | 160 ++++++++++++++++
 tb/tb_mem_burst_initiator.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_initiator.sv
// mem_burst_initiator
//   Burst initiator for a single-port word memory. Takes one command at a
//   time (write or read, base address, length). Write bursts stream words
//   from a valid/ready source into consecutive memory addresses. Read bursts
//   fetch consecutive words and offer them on a valid/ready sink. Addresses
//   wrap modulo DEPTH.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len  command fields
//   wr_valid/wr_ready, wr_data  write-data stream in
//   rd_valid/rd_ready, rd_data  read-data stream out (rd_data registered)
//   mem_addr, mem_wdata, mem_we registered memory request
//   mem_rdata                   memory read data, valid by the edge after
//                               mem_addr changes
//   busy                        any state other than IDLE
//   done, err                   one-cycle end-of-burst pulse; err marks a
//                               rejected command
module mem_burst_initiator #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_we,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR        = 3'd1,
    RD_ADDR   = 3'd2,
    RD_SAMPLE = 3'd3,
    RD_OUT    = 3'd4,
    FIN       = 3'd5
  } state_t;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  rej;       // latched "command rejected" flag
  logic                  fin_last;  // second cycle of FIN: done is shown here
  logic                  accept, wr_hs, rd_hs, last, len_bad;

  assign len_bad = (cmd_len == '0) || (cmd_len > LEN_WIDTH'(DEPTH));
  assign last    = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FIN spans two cycles so that done lands one cycle after the last mem_we
  // (the final write is still being issued during the first FIN cycle).
  always_comb begin
    state_n   = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    accept    = 1'b0;
    wr_hs     = 1'b0;
    rd_hs     = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept = 1'b1;
          if (len_bad)        state_n = FIN;
          else if (cmd_write) state_n = WR;
          else                state_n = RD_ADDR;
        end
      end
      WR: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_hs = 1'b1;
          if (last) state_n = FIN;
        end
      end
      RD_ADDR:   state_n = RD_SAMPLE;
      RD_SAMPLE: state_n = RD_OUT;
      RD_OUT: begin
        if (rd_ready) begin
          rd_hs   = 1'b1;
          state_n = last ? FIN : RD_ADDR;
        end
      end
      FIN: begin
        if (fin_last) begin
          done    = 1'b1;
          err     = rej;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      rej       <= 1'b0;
      fin_last  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      mem_we   <= 1'b0;
      fin_last <= (state == FIN) && !fin_last;
      if (accept) begin
        cur_addr  <= cmd_addr;
        remaining <= cmd_len;
        rej       <= len_bad;
      end
      if (wr_hs) begin
        mem_we    <= 1'b1;
        mem_addr  <= cur_addr;
        mem_wdata <= wr_data;
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
      if (state == RD_ADDR) mem_addr <= cur_addr;
      if (state == RD_SAMPLE) begin
        rd_data  <= mem_rdata;
        rd_valid <= 1'b1;
      end
      if (rd_hs) begin
        rd_valid  <= 1'b0;
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator (WIDTH=8, DEPTH=32) with a simple
// word memory attached to the memory port.
module tb_mem_burst_initiator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy, done, err;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int we_base, done_base;

  logic [7:0] mem [0:31];
  logic [7:0] dat [0:7];

  mem_burst_initiator #(.WIDTH(8), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (done)   done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic w, input logic [4:0] a, input logic [5:0] l);
    check("cmd_ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    tick();
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("cmd_ready_after_accept", cmd_ready, 0);
  endtask

  task automatic finish_burst(input logic exp_err);
    check("done_not_early", done, 0);
    tick();
    check("done_pulse", done, 1);
    check("err_with_done", err, exp_err);
    check("cmd_ready_with_done", cmd_ready, 0);
    tick();
    check("done_single", done, 0);
    check("cmd_ready_after_done", cmd_ready, 1);
    check("busy_after_done", busy, 0);
  endtask

  // Words come from dat[]; gap inserts one wr_valid-low cycle between words.
  task automatic write_burst(input logic [4:0] a, input int n, input bit gap);
    logic [4:0] ea;
    send_cmd(1'b1, a, 6'(n));
    check("wr_ready_in_wr", wr_ready, 1);
    for (int i = 0; i < n; i++) begin
      ea = a + 5'(i);
      wr_valid = 1'b1; wr_data = dat[i];
      tick();
      check("wr_mem_we", mem_we, 1);
      check("wr_mem_addr", mem_addr, ea);
      check("wr_mem_wdata", mem_wdata, dat[i]);
      wr_valid = 1'b0;
      if (gap && i != n - 1) begin
        tick();
        check("wr_gap_no_we", mem_we, 0);
      end
    end
    tick();
    check("wr_ready_dropped", wr_ready, 0);
    check("last_we_gone", mem_we, 0);
    check("done_after_last_we", done, 1);
    check("err_write", err, 0);
    tick();
    check("cmd_ready_after_write", cmd_ready, 1);
  endtask

  // Expected words come from dat[]; stall holds rd_ready low per word.
  task automatic read_burst(input logic [4:0] a, input int n, input int stall);
    logic [4:0] ea;
    send_cmd(1'b0, a, 6'(n));
    for (int i = 0; i < n; i++) begin
      ea = a + 5'(i);
      rd_ready = (stall == 0);
      tick();
      check("rd_mem_addr", mem_addr, ea);
      check("rd_no_we", mem_we, 0);
      tick();
      check("rd_valid_up", rd_valid, 1);
      check("rd_data", rd_data, dat[i]);
      for (int s = 0; s < stall; s++) begin
        tick();
        check("stall_rd_valid", rd_valid, 1);
        check("stall_rd_data", rd_data, dat[i]);
        check("stall_mem_addr", mem_addr, ea);
      end
      rd_ready = 1'b1;
      tick();
      check("rd_valid_down", rd_valid, 0);
    end
    rd_ready = 1'b0;
    finish_burst(1'b0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();
    rst = 1'b0;
    tick();

    // back-to-back write burst at 3
    dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
    we_base = we_cnt;
    write_burst(5'd3, 4, 1'b0);
    check("we_count_wr1", we_cnt - we_base, 4);

    // readback with rd_ready held high, one word per 3 cycles
    done_base = done_cnt;
    read_burst(5'd3, 4, 0);
    check("done_count_rd1", done_cnt - done_base, 1);

    // wrap-around write then stalled readback
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'hC3; dat[3] = 8'hD4;
    write_burst(5'd30, 4, 1'b0);
    read_burst(5'd30, 4, 5);

    // rejected commands; stray wr_valid/rd_ready must be ignored
    we_base = we_cnt;
    wr_valid = 1'b1; rd_ready = 1'b1;
    send_cmd(1'b1, 5'd5, 6'd0);
    finish_burst(1'b1);
    send_cmd(1'b0, 5'd5, 6'd33);
    finish_burst(1'b1);
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("reject_no_we", we_cnt - we_base, 0);

    // write with wr_valid gaps
    dat[0] = 8'h5A; dat[1] = 8'hA5; dat[2] = 8'h3C;
    we_base = we_cnt;
    write_burst(5'd8, 3, 1'b1);
    check("we_count_gaps", we_cnt - we_base, 3);
    read_burst(5'd8, 3, 1);

    // reset after 2 of 6 write handshakes
    done_base = done_cnt;
    send_cmd(1'b1, 5'd12, 6'd6);
    wr_valid = 1'b1; wr_data = 8'h77;
    tick();
    check("mid_we1", mem_we, 1);
    wr_data = 8'h78;
    tick();
    check("mid_we2", mem_we, 1);
    check("mid_addr2", mem_addr, 13);
    #2 rst = 1'b1;
    #1;
    check("arst_mem_we", mem_we, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_mem_wdata", mem_wdata, 0);
    check("arst_wr_ready", wr_ready, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_busy", busy, 0);
    wr_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst_no_done", done_cnt - done_base, 0);

    // read of address 0 (written as 0xC3 by the wrap burst)
    dat[0] = 8'hC3;
    read_burst(5'd0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
